// File: rtl/grid_player_ctrl.sv
// Grid-cell player controller: cell-coordinate position, probe handshake
// for wall lookup, hold-to-repeat movement, portal table, goal/death handling.
module grid_player_ctrl #(
    parameter int CELL_W      = 32,
    parameter int CELL_H      = 30,
    parameter int COLS        = 20,
    parameter int ROWS        = 16,
    parameter int START_COL   = 0,
    parameter int START_ROW   = 0,
    parameter int GOAL_COL    = 17,
    parameter int GOAL_ROW    = 12,
    parameter int NUM_PORTALS = 4,
    parameter int REPEAT_DLY  = 8,
    parameter int REPEAT_PER  = 4,
    localparam int CW         = $clog2(COLS),
    localparam int RW         = $clog2(ROWS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      left,
    input  logic                      up,
    input  logic                      down,
    input  logic                      right,
    input  logic                      press_A,
    input  logic                      gameover,
    input  logic [NUM_PORTALS-1:0]    portal_en,
    input  logic [NUM_PORTALS*CW-1:0] portal_src_col,
    input  logic [NUM_PORTALS*RW-1:0] portal_src_row,
    input  logic [NUM_PORTALS*CW-1:0] portal_dst_col,
    input  logic [NUM_PORTALS*RW-1:0] portal_dst_row,
    output logic                      probe_valid,
    output logic [CW-1:0]             probe_col,
    output logic [RW-1:0]             probe_row,
    input  logic                      probe_ack,
    input  logic                      probe_wall,
    output logic [CW-1:0]             col,
    output logic [RW-1:0]             row,
    output logic [9:0]                xFlr,
    output logic [9:0]                xCeil,
    output logic [9:0]                yFlr,
    output logic [9:0]                yCeil,
    output logic                      win
);

    typedef enum logic [1:0] {IDLE, PROBE, DEAD} state_t;

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d, probe_col_q, probe_col_d;
    logic [RW-1:0]    row_q, row_d, probe_row_q, probe_row_d;
    logic             probe_valid_q, probe_valid_d;
    logic [9:0]       x_flr_q, x_flr_d, x_ceil_q, x_ceil_d;
    logic [9:0]       y_flr_q, y_flr_d, y_ceil_q, y_ceil_d;
    logic             win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       last_dir_q, last_dir_d;
    logic             a_prev_q, a_prev_d;

    logic [3:0]       dir;
    logic             dir_valid, same_dir, move_req, off_grid, a_rise, portal_hit;
    logic [CW-1:0]    tgt_col, portal_col;
    logic [RW-1:0]    tgt_row, portal_row;

    assign dir       = {left, up, down, right};
    assign dir_valid = $onehot(dir);
    assign same_dir  = (dir == last_dir_q);
    assign move_req  = dir_valid && (!same_dir || (cnt_q == '0));
    assign a_rise    = press_A && !a_prev_q;

    // Target cell of the requested step and whether it leaves the grid
    always_comb begin
        tgt_col  = col_q;
        tgt_row  = row_q;
        off_grid = 1'b0;
        if (left) begin
            tgt_col  = col_q - CW'(1);
            off_grid = (col_q == '0);
        end else if (right) begin
            tgt_col  = col_q + CW'(1);
            off_grid = (col_q == CW'(COLS - 1));
        end else if (up) begin
            tgt_row  = row_q - RW'(1);
            off_grid = (row_q == '0);
        end else if (down) begin
            tgt_row  = row_q + RW'(1);
            off_grid = (row_q == RW'(ROWS - 1));
        end
    end

    // Portal lookup: lowest enabled entry whose source is the current cell
    always_comb begin
        portal_hit = 1'b0;
        portal_col = col_q;
        portal_row = row_q;
        for (int unsigned i = 0; i < NUM_PORTALS; i++) begin
            if (!portal_hit && portal_en[i] &&
                portal_src_col[i*CW +: CW] == col_q &&
                portal_src_row[i*RW +: RW] == row_q) begin
                portal_hit = 1'b1;
                portal_col = portal_dst_col[i*CW +: CW];
                portal_row = portal_dst_row[i*RW +: RW];
            end
        end
    end

    // Next-state, repeat counter, position and registered pixel bounds
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        probe_valid_d = probe_valid_q;
        probe_col_d   = probe_col_q;
        probe_row_d   = probe_row_q;
        win_d         = 1'b0;
        a_prev_d      = press_A;
        last_dir_d    = last_dir_q;
        cnt_d         = cnt_q;

        // Repeat counter runs independently of the FSM; accepted requests
        // below override it with a reload.
        if (!dir_valid) begin
            last_dir_d = '0;
            cnt_d      = '0;
        end else if (same_dir && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (col_q == CW'(GOAL_COL) && row_q == RW'(GOAL_ROW)) begin
                    win_d = 1'b1;
                    col_d = CW'(START_COL);
                    row_d = RW'(START_ROW);
                end else if (move_req) begin
                    last_dir_d = dir;
                    cnt_d      = same_dir ? CNT_W'(REPEAT_PER) : CNT_W'(REPEAT_DLY);
                    if (!off_grid) begin
                        probe_col_d   = tgt_col;
                        probe_row_d   = tgt_row;
                        probe_valid_d = 1'b1;
                        state_d       = PROBE;
                    end
                end else if (a_rise && !dir_valid && portal_hit) begin
                    col_d = portal_col;
                    row_d = portal_row;
                end
            end
            PROBE: begin
                if (probe_ack) begin
                    probe_valid_d = 1'b0;
                    state_d       = IDLE;
                    if (!probe_wall) begin
                        col_d = probe_col_q;
                        row_d = probe_row_q;
                    end
                end
            end
            default: begin
                last_dir_d = last_dir_q;
                cnt_d      = cnt_q;
            end
        endcase

        if (gameover) begin
            state_d       = DEAD;
            probe_valid_d = 1'b0;
            col_d         = col_q;
            row_d         = row_q;
            win_d         = 1'b0;
            last_dir_d    = last_dir_q;
            cnt_d         = cnt_q;
        end

        if (state_d == DEAD) begin
            x_flr_d  = 10'(COLS * CELL_W);
            x_ceil_d = 10'(COLS * CELL_W);
            y_flr_d  = '0;
            y_ceil_d = '0;
        end else begin
            x_flr_d  = 10'(col_d) * 10'(CELL_W);
            y_flr_d  = 10'(row_d) * 10'(CELL_H);
            x_ceil_d = x_flr_d + 10'(CELL_W);
            y_ceil_d = y_flr_d + 10'(CELL_H);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            col_q         <= CW'(START_COL);
            row_q         <= RW'(START_ROW);
            probe_valid_q <= 1'b0;
            probe_col_q   <= '0;
            probe_row_q   <= '0;
            x_flr_q       <= 10'(START_COL * CELL_W);
            x_ceil_q      <= 10'(START_COL * CELL_W + CELL_W);
            y_flr_q       <= 10'(START_ROW * CELL_H);
            y_ceil_q      <= 10'(START_ROW * CELL_H + CELL_H);
            win_q         <= 1'b0;
            cnt_q         <= '0;
            last_dir_q    <= '0;
            a_prev_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            probe_valid_q <= probe_valid_d;
            probe_col_q   <= probe_col_d;
            probe_row_q   <= probe_row_d;
            x_flr_q       <= x_flr_d;
            x_ceil_q      <= x_ceil_d;
            y_flr_q       <= y_flr_d;
            y_ceil_q      <= y_ceil_d;
            win_q         <= win_d;
            cnt_q         <= cnt_d;
            last_dir_q    <= last_dir_d;
            a_prev_q      <= a_prev_d;
        end
    end

    assign probe_valid = probe_valid_q;
    assign probe_col   = probe_col_q;
    assign probe_row   = probe_row_q;
    assign col         = col_q;
    assign row         = row_q;
    assign xFlr        = x_flr_q;
    assign xCeil       = x_ceil_q;
    assign yFlr        = y_flr_q;
    assign yCeil       = y_ceil_q;
    assign win         = win_q;

endmodule

// File: tb/tb_grid_player_ctrl.sv
// Self-checking bench for grid_player_ctrl: stepping with auto-repeat,
// walls, grid edges, portals, goal return, gameover and reset.
module tb_grid_player_ctrl;

    localparam int CW = 5;
    localparam int RW = 4;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic reset, left, up, down, right, press_A, gameover;
    logic [NP-1:0]    portal_en;
    logic [NP*CW-1:0] portal_src_col, portal_dst_col;
    logic [NP*RW-1:0] portal_src_row, portal_dst_row;
    logic             probe_valid, probe_ack, probe_wall;
    logic [CW-1:0]    probe_col, col;
    logic [RW-1:0]    probe_row, row;
    logic [9:0]       xFlr, xCeil, yFlr, yCeil;
    logic             win;

    int total = 0;
    int bad   = 0;
    bit auto_ack  = 1'b0;
    bit wall_mode = 1'b0;

    typedef struct {int e; int c; int r;} exp_t;
    exp_t moves[$];
    exp_t probes[$];

    always #5 clk = ~clk;

    grid_player_ctrl #(
        .CELL_W(32), .CELL_H(30), .COLS(20), .ROWS(16),
        .START_COL(0), .START_ROW(0), .GOAL_COL(17), .GOAL_ROW(12),
        .NUM_PORTALS(NP), .REPEAT_DLY(8), .REPEAT_PER(4)
    ) dut (
        .clk(clk), .reset(reset),
        .left(left), .up(up), .down(down), .right(right),
        .press_A(press_A), .gameover(gameover),
        .portal_en(portal_en),
        .portal_src_col(portal_src_col), .portal_src_row(portal_src_row),
        .portal_dst_col(portal_dst_col), .portal_dst_row(portal_dst_row),
        .probe_valid(probe_valid), .probe_col(probe_col), .probe_row(probe_row),
        .probe_ack(probe_ack), .probe_wall(probe_wall),
        .col(col), .row(row),
        .xFlr(xFlr), .xCeil(xCeil), .yFlr(yFlr), .yCeil(yCeil),
        .win(win)
    );

    // Advance to the next falling edge; the maze ROM model answers a
    // pending probe so the ack is sampled on the following rising edge.
    task automatic tick();
        @(negedge clk);
        probe_ack  = auto_ack ? probe_valid : 1'b0;
        probe_wall = wall_mode;
    endtask

    task automatic set_portal(input int i, input bit en, input int sc, input int sr,
                              input int dc, input int dr);
        portal_en[i] = en;
        portal_src_col[i*CW +: CW] = CW'(sc);
        portal_src_row[i*RW +: RW] = RW'(sr);
        portal_dst_col[i*CW +: CW] = CW'(dc);
        portal_dst_row[i*RW +: RW] = RW'(dr);
    endtask

    task automatic do_reset();
        reset = 1'b1; left = 0; up = 0; down = 0; right = 0; press_A = 0; gameover = 0;
        auto_ack = 1'b0; wall_mode = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic pulse_a();
        press_A = 1'b1; tick();
        press_A = 1'b0; tick();
    endtask

    task automatic test_reset();
        portal_en = '0; portal_src_col = '0; portal_src_row = '0;
        portal_dst_col = '0; portal_dst_row = '0;
        do_reset();
        total++;
        if (col !== 5'd0 || row !== 4'd0 || xFlr !== 10'd0 || xCeil !== 10'd32 ||
            yFlr !== 10'd0 || yCeil !== 10'd30 || probe_valid !== 1'b0 ||
            probe_col !== 5'd0 || probe_row !== 4'd0 || win !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: got col=%0d row=%0d x=%0d/%0d y=%0d/%0d pv=%b pc=%0d pr=%0d win=%b exp 0 0 0/32 0/30 0 0 0 0",
                     col, row, xFlr, xCeil, yFlr, yCeil, probe_valid, probe_col, probe_row, win);
        end
        // reset while a probe is outstanding
        right = 1'b1; tick();
        total++;
        if (probe_valid !== 1'b1 || probe_col !== 5'd1) begin
            bad++;
            $display("FAIL reset_probe_start: got pv=%b pc=%0d exp 1 1", probe_valid, probe_col);
        end
        reset = 1'b1; right = 1'b0; tick();
        total++;
        if (probe_valid !== 1'b0 || col !== 5'd0 || xFlr !== 10'd0 || xCeil !== 10'd32) begin
            bad++;
            $display("FAIL reset_mid_probe: got pv=%b col=%0d x=%0d/%0d exp 0 0 0/32",
                     probe_valid, col, xFlr, xCeil);
        end
        reset = 1'b0; tick();
    endtask

    task automatic test_repeat_move();
        int   prev_c;
        exp_t m;
        do_reset();
        auto_ack = 1'b1; wall_mode = 1'b0;
        moves = {};
        moves.push_back('{2, 1, 0});
        moves.push_back('{11, 2, 0});
        moves.push_back('{16, 3, 0});
        moves.push_back('{21, 4, 0});
        prev_c = int'(col);
        right = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            tick();
            if (probe_valid) begin
                total++;
                if (int'(probe_col) !== int'(col) + 1 || probe_row !== row) begin
                    bad++;
                    $display("FAIL repeat_probe_target e=%0d: got %0d,%0d exp %0d,%0d",
                             e, probe_col, probe_row, int'(col) + 1, row);
                end
            end
            if (int'(col) != prev_c) begin
                total++;
                if (moves.size() == 0) begin
                    bad++;
                    $display("FAIL repeat_extra_move e=%0d: got col=%0d exp no move", e, col);
                end else begin
                    m = moves.pop_front();
                    if (e != m.e || int'(col) !== m.c || int'(row) !== m.r ||
                        xFlr !== 10'(m.c * 32) || xCeil !== 10'(m.c * 32 + 32) ||
                        yFlr !== 10'(m.r * 30) || yCeil !== 10'(m.r * 30 + 30)) begin
                        bad++;
                        $display("FAIL repeat_move: got e=%0d col=%0d row=%0d x=%0d/%0d y=%0d/%0d exp e=%0d col=%0d row=%0d x=%0d",
                                 e, col, row, xFlr, xCeil, yFlr, yCeil, m.e, m.c, m.r, m.c * 32);
                    end
                end
                prev_c = int'(col);
            end
            if (e == 21) right = 1'b0;
        end
        total++;
        if (moves.size() != 0) begin
            bad++;
            $display("FAIL repeat_missing_moves: got %0d left exp 0", moves.size());
        end
    endtask

    task automatic test_wall();
        bit   pv_prev;
        exp_t p;
        do_reset();
        portal_en = '0;
        set_portal(0, 1'b1, 0, 0, 5, 3);
        set_portal(1, 1'b1, 0, 0, 9, 9);
        pulse_a();
        total++;
        if (col !== 5'd5 || row !== 4'd3 || xFlr !== 10'd160 || yFlr !== 10'd90) begin
            bad++;
            $display("FAIL portal_priority: got %0d,%0d x=%0d y=%0d exp 5,3 x=160 y=90",
                     col, row, xFlr, yFlr);
        end
        auto_ack = 1'b1; wall_mode = 1'b1;
        probes = {};
        probes.push_back('{1, 5, 4});
        probes.push_back('{10, 5, 4});
        pv_prev = 1'b0;
        down = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (probe_valid && !pv_prev) begin
                total++;
                if (probes.size() == 0) begin
                    bad++;
                    $display("FAIL wall_extra_probe e=%0d: got probe exp none", e);
                end else begin
                    p = probes.pop_front();
                    if (e != p.e || int'(probe_col) !== p.c || int'(probe_row) !== p.r) begin
                        bad++;
                        $display("FAIL wall_probe: got e=%0d %0d,%0d exp e=%0d %0d,%0d",
                                 e, probe_col, probe_row, p.e, p.c, p.r);
                    end
                end
            end
            pv_prev = probe_valid;
            total++;
            if (col !== 5'd5 || row !== 4'd3 || yFlr !== 10'd90) begin
                bad++;
                $display("FAIL wall_position e=%0d: got %0d,%0d y=%0d exp 5,3 y=90", e, col, row, yFlr);
            end
        end
        down = 1'b0; wall_mode = 1'b0;
        total++;
        if (probes.size() != 0) begin
            bad++;
            $display("FAIL wall_missing_probe: got %0d left exp 0", probes.size());
        end
    endtask

    task automatic test_edges();
        int pv_cnt;
        do_reset();
        auto_ack = 1'b1;
        portal_en = '0;
        pv_cnt = 0;
        left = 1'b1;
        for (int e = 0; e < 12; e++) begin tick(); if (probe_valid) pv_cnt++; end
        left = 1'b0;
        total++;
        if (pv_cnt != 0 || xFlr !== 10'd0 || col !== 5'd0) begin
            bad++;
            $display("FAIL edge_left: got probes=%0d x=%0d col=%0d exp 0 0 0", pv_cnt, xFlr, col);
        end
        set_portal(0, 1'b1, 0, 0, 3, 15);
        pulse_a();
        pv_cnt = 0;
        down = 1'b1;
        for (int e = 0; e < 12; e++) begin tick(); if (probe_valid) pv_cnt++; end
        down = 1'b0;
        total++;
        if (pv_cnt != 0 || row !== 4'd15 || yFlr !== 10'd450 || yCeil !== 10'd480) begin
            bad++;
            $display("FAIL edge_down: got probes=%0d row=%0d y=%0d/%0d exp 0 15 450/480",
                     pv_cnt, row, yFlr, yCeil);
        end
        set_portal(1, 1'b1, 3, 15, 19, 7);
        pulse_a();
        pv_cnt = 0;
        right = 1'b1;
        for (int e = 0; e < 12; e++) begin tick(); if (probe_valid) pv_cnt++; end
        right = 1'b0;
        total++;
        if (pv_cnt != 0 || col !== 5'd19 || xFlr !== 10'd608 || xCeil !== 10'd640) begin
            bad++;
            $display("FAIL edge_right: got probes=%0d col=%0d x=%0d/%0d exp 0 19 608/640",
                     pv_cnt, col, xFlr, xCeil);
        end
        portal_en = '0;
    endtask

    task automatic test_portal();
        do_reset();
        portal_en = '0;
        set_portal(0, 1'b1, 7, 5, 13, 1);
        set_portal(1, 1'b1, 0, 0, 7, 5);
        set_portal(2, 1'b0, 13, 1, 0, 0);
        press_A = 1'b1; tick();
        total++;
        if (col !== 5'd7 || row !== 4'd5) begin
            bad++;
            $display("FAIL portal_first: got %0d,%0d exp 7,5", col, row);
        end
        tick(); tick(); tick();
        total++;
        if (col !== 5'd7 || row !== 4'd5) begin
            bad++;
            $display("FAIL portal_hold: got %0d,%0d exp 7,5", col, row);
        end
        press_A = 1'b0; tick();
        press_A = 1'b1; tick();
        total++;
        if (col !== 5'd13 || row !== 4'd1 || xFlr !== 10'd416 || xCeil !== 10'd448 ||
            yFlr !== 10'd30 || yCeil !== 10'd60) begin
            bad++;
            $display("FAIL portal_jump: got %0d,%0d x=%0d/%0d y=%0d/%0d exp 13,1 416/448 30/60",
                     col, row, xFlr, xCeil, yFlr, yCeil);
        end
        press_A = 1'b0; tick();
        press_A = 1'b1; tick();
        press_A = 1'b0; tick();
        total++;
        if (col !== 5'd13 || row !== 4'd1) begin
            bad++;
            $display("FAIL portal_disabled: got %0d,%0d exp 13,1", col, row);
        end
        portal_en = '0;
    endtask

    task automatic test_dir_vs_portal();
        do_reset();
        portal_en = '0;
        set_portal(0, 1'b1, 0, 0, 5, 5);
        right = 1'b1; press_A = 1'b1; tick();
        total++;
        if (probe_valid !== 1'b1 || probe_col !== 5'd1 || col !== 5'd0 || row !== 4'd0) begin
            bad++;
            $display("FAIL dir_beats_portal: got pv=%b pc=%0d pos=%0d,%0d exp 1 1 0,0",
                     probe_valid, probe_col, col, row);
        end
        right = 1'b0; press_A = 1'b0; auto_ack = 1'b1;
        tick(); tick();
        total++;
        if (col !== 5'd1 || row !== 4'd0 || xFlr !== 10'd32) begin
            bad++;
            $display("FAIL dir_step_done: got %0d,%0d x=%0d exp 1,0 32", col, row, xFlr);
        end
        portal_en = '0;
    endtask

    task automatic test_goal();
        bit exp_win;
        do_reset();
        portal_en = '0;
        set_portal(0, 1'b1, 0, 0, 16, 12);
        pulse_a();
        total++;
        if (col !== 5'd16 || row !== 4'd12) begin
            bad++;
            $display("FAIL goal_setup: got %0d,%0d exp 16,12", col, row);
        end
        auto_ack = 1'b1; wall_mode = 1'b0;
        right = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            exp_win = (e == 3);
            total++;
            if (win !== exp_win) begin
                bad++;
                $display("FAIL goal_win e=%0d: got %b exp %b", e, win, exp_win);
            end
            if (e == 2) begin
                total++;
                if (col !== 5'd17 || row !== 4'd12 || xFlr !== 10'd544 || yFlr !== 10'd360) begin
                    bad++;
                    $display("FAIL goal_arrive: got %0d,%0d x=%0d y=%0d exp 17,12 544 360",
                             col, row, xFlr, yFlr);
                end
            end
            if (e == 3) begin
                total++;
                if (col !== 5'd0 || row !== 4'd0 || xFlr !== 10'd0 || yFlr !== 10'd0) begin
                    bad++;
                    $display("FAIL goal_return: got %0d,%0d x=%0d y=%0d exp 0,0 0 0",
                             col, row, xFlr, yFlr);
                end
                right = 1'b0;
            end
        end
        portal_en = '0;
    endtask

    task automatic test_gameover();
        int pv_cnt;
        do_reset();
        auto_ack = 1'b1;
        right = 1'b1; tick();
        total++;
        if (probe_valid !== 1'b1) begin
            bad++;
            $display("FAIL dead_probe_start: got pv=%b exp 1", probe_valid);
        end
        gameover = 1'b1; tick();
        total++;
        if (probe_valid !== 1'b0 || col !== 5'd0 || xFlr !== 10'd640 || xCeil !== 10'd640 ||
            yFlr !== 10'd0 || yCeil !== 10'd0) begin
            bad++;
            $display("FAIL dead_enter: got pv=%b col=%0d x=%0d/%0d y=%0d/%0d exp 0 0 640/640 0/0",
                     probe_valid, col, xFlr, xCeil, yFlr, yCeil);
        end
        gameover = 1'b0;
        pv_cnt = 0;
        for (int e = 0; e < 12; e++) begin
            right = e[0]; down = ~e[0]; press_A = e[1];
            tick();
            if (probe_valid) pv_cnt++;
        end
        right = 1'b0; down = 1'b0; press_A = 1'b0;
        total++;
        if (pv_cnt != 0 || col !== 5'd0 || row !== 4'd0 || xFlr !== 10'd640 || yCeil !== 10'd0) begin
            bad++;
            $display("FAIL dead_hold: got probes=%0d pos=%0d,%0d x=%0d yc=%0d exp 0 0,0 640 0",
                     pv_cnt, col, row, xFlr, yCeil);
        end
        reset = 1'b1; tick();
        reset = 1'b0;
        total++;
        if (col !== 5'd0 || row !== 4'd0 || xFlr !== 10'd0 || xCeil !== 10'd32 ||
            yFlr !== 10'd0 || yCeil !== 10'd30 || probe_valid !== 1'b0) begin
            bad++;
            $display("FAIL dead_reset: got pos=%0d,%0d x=%0d/%0d y=%0d/%0d pv=%b exp 0,0 0/32 0/30 0",
                     col, row, xFlr, xCeil, yFlr, yCeil, probe_valid);
        end
        right = 1'b1; auto_ack = 1'b1;
        tick(); tick();
        right = 1'b0;
        total++;
        if (col !== 5'd1 || xFlr !== 10'd32) begin
            bad++;
            $display("FAIL dead_recover_step: got col=%0d x=%0d exp 1 32", col, xFlr);
        end
    endtask

    initial begin
        probe_ack = 1'b0; probe_wall = 1'b0;
        test_reset();
        test_repeat_move();
        test_wall();
        test_edges();
        test_portal();
        test_dir_vs_portal();
        test_goal();
        test_gameover();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_player_ctrl.md
# grid_player_ctrl

Parametrised grid-cell player controller for the maze game. It is the successor to the fixed 32x30-pixel player mover. It holds the player position in cell coordinates and emits registered pixel bounds to the VGA drawer. Each step asks the maze ROM for the target cell through a probe handshake instead of a combinational wall flag. It adds hold-to-repeat movement and a runtime-loaded portal table, and it sits between the N8 controller decoder and the pixel-colour mux.

## Interface
- CELL_W, 32, cell width in pixels
- CELL_H, 30, cell height in pixels
- COLS, 20, grid columns; CW = $clog2(COLS)
- ROWS, 16, grid rows; RW = $clog2(ROWS)
- START_COL / START_ROW, 0 / 0, spawn cell
- GOAL_COL / GOAL_ROW, 17 / 12, goal cell
- NUM_PORTALS, 4, portal table entries
- REPEAT_DLY, 8, hold cycles before the first auto-repeat
- REPEAT_PER, 4, cycles between later auto-repeats
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- left, up, down, right  in  1 each  controller direction levels
- press_A  in  1  controller A button level
- gameover  in  1  lava/fail flag from game logic
- portal_en  in  NUM_PORTALS  per-entry enable
- portal_src_col / portal_dst_col  in  NUM_PORTALS*CW  packed; entry i is bits [i*CW +: CW]
- portal_src_row / portal_dst_row  in  NUM_PORTALS*RW  packed; same packing as the column buses
- probe_valid  out  1  wall lookup request
- probe_col / probe_row  out  CW / RW  target cell under probe
- probe_ack  in  1  lookup result valid
- probe_wall  in  1  target cell is a wall; sampled only with probe_ack
- col / row  out  CW / RW  current cell
- xFlr, xCeil, yFlr, yCeil  out  10 each  registered pixel bounds of the player block
- win  out  1  one-cycle pulse when the player reaches the goal

## Operation
- States: IDLE, PROBE, DEAD.
- Reset values:
  - state IDLE; col = START_COL, row = START_ROW.
  - xFlr = START_COL*CELL_W, xCeil = xFlr + CELL_W, yFlr = START_ROW*CELL_H, yCeil = yFlr + CELL_H.
  - probe_valid = 0, probe_col = probe_row = 0, win = 0, repeat counter 0, last direction none.
- Direction pattern is valid only when exactly one of left/up/down/right is high. Any other combination is no direction.
- Move request (IDLE only) fires when the pattern is valid and either:
  - the pattern differs from the last accepted pattern (new press), or
  - the repeat counter equals 0.
- On an accepted new press, load the counter with REPEAT_DLY. On an accepted repeat, load it with REPEAT_PER.
- The counter decrements each cycle, saturating at 0, while the pattern stays unchanged, in any state. If the pattern becomes invalid, clear last direction and counter.
- Edge check: a move request whose target leaves the grid is dropped in IDLE with no probe. Off-grid means col 0 and left, col COLS-1 and right, row 0 and up, or row ROWS-1 and down. The counter is still reloaded.
- A legal request latches the target into probe_col/probe_row, raises probe_valid, and goes to PROBE.
- PROBE: probe_valid and probe_col/probe_row stay stable until probe_ack.
  - probe_ack with probe_wall=0: col/row take the target and pixel bounds update on the same edge.
  - probe_ack with probe_wall=1: position is unchanged.
  - Either way, drop probe_valid and return to IDLE.
- Portal: in IDLE, a rising edge of press_A with no valid direction, on a cell equal to the src of an enabled entry, moves to that entry's dst. The lowest matching index wins. No probe is issued and destination cells are trusted.
- Goal: when col/row become GOAL, win pulses 1 on the next cycle and the position returns to START on that same edge.
- Pixel arithmetic: xFlr = col*CELL_W and yFlr = row*CELL_H, zero-extended to 10 bits. xCeil = xFlr + CELL_W and yCeil = yFlr + CELL_H. Parameters must satisfy COLS*CELL_W ≤ 1023 and ROWS*CELL_H ≤ 1023.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Move latency:
  - request sampled at edge k → probe_valid high after k.
  - ack sampled at edge m ≥ k+1 → new col/row and pixel bounds after m.
  - Minimum press-to-move is 2 edges.
- Portal latency is 1 edge after the press_A rise is sampled. Goal return is 1 edge after arrival.
- gameover has priority over everything except reset.
  - In any state: state becomes DEAD, probe_valid drops on the next edge, and any pending ack is ignored.
  - DEAD: xFlr = xCeil = COLS*CELL_W, yFlr = yCeil = 0; all inputs ignored until reset.
- Reset mid-PROBE restores all reset values on the next edge, and probe_valid drops on that edge.
- If a direction and a press_A rise occur in the same cycle, the direction wins.

## Test plan
- Reset, then hold right with probe_ack returned 1 cycle after probe_valid and probe_wall=0. → xFlr 0→32 (xCeil 64) two edges after the press; a second step after about 8 more hold cycles, then one every ~4 cycles.
- At col 5 row 3, press down with probe_wall=1. → probe_col=5 and probe_row=4 seen, position unchanged, return to IDLE, no second probe until repeat expiry.
- At col 0, press left. → probe_valid never asserts and xFlr stays 0. At row 15, press down. → no probe.
- Portal 0 enabled with src (7,5) and dst (13,1); player at (7,5), pulse press_A. → col=13, row=1, xFlr=416, yFlr=30 after 1 edge. Holding press_A produces no further jump.
- Step into (17,12). → win pulses one cycle, then col/row = 0/0 and xFlr/yFlr = 0.
- Assert gameover mid-PROBE. → probe_valid low next edge, xFlr=xCeil=640, yFlr=yCeil=0, directions ignored; reset restores (0,0).
